hazard_unit_v2: RTL and testbench

- Next-generation pipeline hazard controller for the 5-stage MIPS core.
- Keeps the existing duties: E- and D-stage forwarding, load-use stall, branch-compare stall.
- Adds four things:
  - a sequential multi-cycle divide/multiply stall FSM with a latency counter;
  - per-stage stall/flush vectors for memory-wait freezes;
  - precise exception flush from M;
  - parametrised register-address width and divider latency.
- Sits beside the datapath and drives every pipeline register's enable and clear.

---
 rtl/hazard_unit_v2.sv | 192 +++++++++++++++++++
 tb/tb_hazard_unit_v2.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_v2.sv
// Pipeline hazard controller for the 5-stage MIPS core: operand forwarding,
// load-use and branch-compare stalls, a multi-cycle divider stall FSM and stall/flush composition.
module hazard_unit_v2 #(
  parameter int AW      = 5,
  parameter int DIV_LAT = 32,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoRegE,
  input  logic          memtoRegM,
  input  logic          branchD,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] reg_waddrE,
  input  logic [AW-1:0] reg_waddrM,
  input  logic [AW-1:0] reg_waddrW,
  input  logic          divE,
  input  logic          exceptM,
  input  logic          inst_stall,
  input  logic          data_stall,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          forwardAD,
  output logic          forwardBD,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          div_busy,
  output logic          div_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam logic [CW-1:0] LP_CNT_LOAD = CW'(DIV_LAT - 1);

  div_state_t    r_state;
  div_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_was_done;

  logic [AW-1:0] w_srcE [2];
  logic [AW-1:0] w_srcD [2];
  logic [1:0]    w_fwdE [2];
  logic          w_fwdD [2];
  logic          w_lw_hit [2];
  logic          w_br_hitE [2];
  logic          w_br_hitM [2];

  logic w_lwstall;
  logic w_branch_stall;
  logic w_div_start;
  logic w_busy;

  assign w_srcE[0] = rsE;
  assign w_srcE[1] = rtE;
  assign w_srcD[0] = rsD;
  assign w_srcD[1] = rtD;

  // Index 0 is the rs operand, index 1 the rt operand; register 0 is never a hazard.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic w_nzE;
      logic w_nzD;
      assign w_nzE = |w_srcE[gi];
      assign w_nzD = |w_srcD[gi];

      assign w_fwdE[gi] = (w_nzE && regwriteM && (w_srcE[gi] == reg_waddrM)) ? 2'b10 :
                          (w_nzE && regwriteW && (w_srcE[gi] == reg_waddrW)) ? 2'b01 :
                                                                               2'b00;
      assign w_fwdD[gi]    = w_nzD && regwriteM && (w_srcD[gi] == reg_waddrM);
      assign w_lw_hit[gi]  = w_srcD[gi] == rtE;
      assign w_br_hitE[gi] = w_nzD && (w_srcD[gi] == reg_waddrE);
      assign w_br_hitM[gi] = w_nzD && (w_srcD[gi] == reg_waddrM);
    end
  endgenerate

  assign forwardAE = w_fwdE[0];
  assign forwardBE = w_fwdE[1];
  assign forwardAD = w_fwdD[0];
  assign forwardBD = w_fwdD[1];

  assign w_lwstall      = memtoRegE && (|rtE) && (w_lw_hit[0] || w_lw_hit[1]);
  assign w_branch_stall = branchD &&
                          ((regwriteE && (w_br_hitE[0] || w_br_hitE[1])) ||
                           (memtoRegM && (w_br_hitM[0] || w_br_hitM[1])));

  // A divE still asserted right after DONE is the finished instruction, not a new one.
  assign w_div_start = divE && !exceptM && !data_stall && !inst_stall && !r_was_done;
  assign w_busy      = (r_state == S_BUSY);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (exceptM) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_div_start) begin
            w_state_next = S_BUSY;
            w_cnt_next   = LP_CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (!data_stall) begin
            if (r_cnt == '0) begin
              w_state_next = S_DONE;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_was_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_was_done <= (r_state == S_DONE);
    end
  end

  assign div_busy = w_busy;
  assign div_done = (r_state == S_DONE);

  // Highest-priority rule first; a pending exception waits out a data-memory freeze.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM && !data_stall) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (inst_stall || data_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (w_busy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (w_lwstall || w_branch_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed and randomized checks of hazard_unit_v2 against a behavioural model
// that tracks the divider as "busy cycles remaining" plus a done flag.
module tb_hazard_unit_v2;

  localparam int AW   = 5;
  localparam int DLAT = 4;
  localparam int CWP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwriteE, regwriteM, regwriteW;
  logic          memtoRegE, memtoRegM, branchD;
  logic [AW-1:0] rsD, rtD, rsE, rtE;
  logic [AW-1:0] reg_waddrE, reg_waddrM, reg_waddrW;
  logic          divE, exceptM, inst_stall, data_stall;
  logic [1:0]    forwardAE, forwardBE;
  logic          forwardAD, forwardBD;
  logic          stallF, stallD, stallE, stallM, stallW;
  logic          flushD, flushE, flushM, flushW;
  logic          div_busy, div_done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_left  = 0;
  bit m_done  = 1'b0;
  bit m_after = 1'b0;

  hazard_unit_v2 #(.AW(AW), .DIV_LAT(DLAT), .CW(CWP)) dut (
    .clk(clk), .rst(rst),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM), .branchD(branchD),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .reg_waddrE(reg_waddrE), .reg_waddrM(reg_waddrM), .reg_waddrW(reg_waddrW),
    .divE(divE), .exceptM(exceptM), .inst_stall(inst_stall), .data_stall(data_stall),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwdE(input logic [AW-1:0] a);
    if (a != 0 && regwriteM && a == reg_waddrM) return 2'b10;
    if (a != 0 && regwriteW && a == reg_waddrW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_fwdD(input logic [AW-1:0] a);
    return (a != 0) && regwriteM && (a == reg_waddrM);
  endfunction

  function automatic logic ref_src_hit(input logic [AW-1:0] a, input logic [AW-1:0] w);
    return (a != 0) && (a == w);
  endfunction

  task automatic check_all();
    logic [5:0] e_fwd;
    logic [4:0] e_st;
    logic [3:0] e_fl;
    logic       lw, br;
    e_fwd = {ref_fwdE(rsE), ref_fwdE(rtE), ref_fwdD(rsD), ref_fwdD(rtD)};
    lw = memtoRegE && (rtE != 0) && (rsD == rtE || rtD == rtE);
    br = branchD && ((regwriteE && (ref_src_hit(rsD, reg_waddrE) || ref_src_hit(rtD, reg_waddrE))) ||
                     (memtoRegM && (ref_src_hit(rsD, reg_waddrM) || ref_src_hit(rtD, reg_waddrM))));
    e_st = 5'b00000;
    e_fl = 4'b0000;
    if (exceptM && !data_stall)       e_fl = 4'b1111;
    else if (inst_stall || data_stall) e_st = 5'b11111;
    else if (m_left > 0) begin e_st = 5'b11100; e_fl = 4'b0010; end
    else if (lw || br)   begin e_st = 5'b11000; e_fl = 4'b0100; end
    chk("forward", 8'({forwardAE, forwardBE, forwardAD, forwardBD}), 8'(e_fwd));
    chk("stalls", 8'({stallF, stallD, stallE, stallM, stallW}), 8'(e_st));
    chk("flushes", 8'({flushD, flushE, flushM, flushW}), 8'(e_fl));
    chk("div_status", 8'({div_busy, div_done}), 8'({m_left > 0, m_done}));
  endtask

  task automatic model_edge();
    bit nafter;
    nafter = m_done;
    if (exceptM) begin
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (!data_stall) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (divE && !data_stall && !inst_stall && !m_after) begin
      m_left = DLAT;
    end
    m_after = nafter;
  endtask

  task automatic step();
    #2;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoRegE = 0; memtoRegM = 0; branchD = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    reg_waddrE = 0; reg_waddrM = 0; reg_waddrW = 0;
    divE = 0; exceptM = 0; inst_stall = 0; data_stall = 0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #3;
    check_all();
    chk("reset_div", 8'({div_busy, div_done}), 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding into E
    clr(); rsE = 3; rtE = 5; reg_waddrM = 3; regwriteM = 1;
    #2; chk("fwdAE_from_M", 8'(forwardAE), 8'h02); #0; step();
    clr(); rsE = 0; reg_waddrM = 0; regwriteM = 1;
    #2; chk("fwdAE_reg0", 8'(forwardAE), 8'h00); step();
    clr(); rsE = 3; reg_waddrM = 3; reg_waddrW = 3; regwriteM = 1; regwriteW = 1;
    #2; chk("fwdAE_M_over_W", 8'(forwardAE), 8'h02); step();
    clr(); rtE = 6; reg_waddrW = 6; regwriteW = 1; reg_waddrM = 4; regwriteM = 1;
    step();

    // Load-use
    clr(); memtoRegE = 1; rtE = 2; rtD = 2;
    #2; chk("lwstall_stalls", 8'({stallF, stallD, flushE}), 8'h07); step();
    clr(); memtoRegE = 1; rtE = 0; rtD = 0;
    step();

    // Branch compare then forward from M
    clr(); branchD = 1; rsD = 7; regwriteE = 1; reg_waddrE = 7;
    #2; chk("branch_stall", 8'({stallF, stallD, flushE}), 8'h07); step();
    clr(); branchD = 1; rsD = 7; regwriteM = 1; reg_waddrM = 7;
    #2; chk("branch_fwdAD", 8'({forwardAD, stallF}), 8'h02); step();

    // Divide, plain: 4 busy cycles, a done pulse, no retrigger after done
    clr(); divE = 1;
    for (int i = 0; i < 8; i++) step();
    clr(); step();

    // Divide with a 2-cycle data_stall mid-busy
    clr(); divE = 1;
    step(); step();
    data_stall = 1; step(); step();
    data_stall = 0;
    for (int i = 0; i < 7; i++) step();
    clr(); step();

    // Exception at busy cycle 2
    clr(); divE = 1;
    step(); step();
    exceptM = 1;
    #2; chk("except_flush", 8'({flushD, flushE, flushM, flushW, stallF}), 8'h1E); step();
    clr(); step(); step();

    // Asynchronous reset mid-busy
    clr(); divE = 1;
    step(); step();
    #1;
    rst = 1'b1;
    m_left = 0; m_done = 1'b0; m_after = 1'b0;
    #1;
    chk("rst_async_busy", 8'(div_busy), 8'h00);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    divE = 0;
    step(); step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      regwriteE  = 1'($urandom_range(0, 1));
      regwriteM  = 1'($urandom_range(0, 1));
      regwriteW  = 1'($urandom_range(0, 1));
      memtoRegE  = 1'($urandom_range(0, 1));
      memtoRegM  = 1'($urandom_range(0, 1));
      branchD    = 1'($urandom_range(0, 1));
      rsD        = AW'($urandom_range(0, 3));
      rtD        = AW'($urandom_range(0, 3));
      rsE        = AW'($urandom_range(0, 3));
      rtE        = AW'($urandom_range(0, 3));
      reg_waddrE = AW'($urandom_range(0, 3));
      reg_waddrM = AW'($urandom_range(0, 3));
      reg_waddrW = AW'($urandom_range(0, 3));
      divE       = ($urandom_range(0, 3) == 0);
      exceptM    = ($urandom_range(0, 15) == 0);
      inst_stall = ($urandom_range(0, 7) == 0);
      data_stall = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
